// File: rtl/ovi_pkg.sv
// Shared types and sizes for the OVI issue controller and its scoreboard table.
`ifndef OVI_DEFINITIONS_SV
`include "definitions.sv"
`endif

package ovi_pkg;

  localparam int INSTR_W  = `OVI_INSTR_WIDTH;
  localparam int VL_W     = `OVI_VL_WIDTH;
  localparam int SEW_W    = `OVI_SEW_WIDTH;
  localparam int DATA_W   = `OVI_DATA_WIDTH;
  localparam int SCALAR_W = `OVI_SCALAROPND_WIDTH;
  localparam int SBID_W   = `OVI_SBID_WIDTH;
  localparam int SB_DEPTH = 2 ** SBID_W;
  localparam int CRED_W   = 4;
  localparam int OUTST_W  = 6;
  localparam int DST_W    = 5;

  typedef logic [SBID_W-1:0] sb_id_t;

  typedef struct packed {
    logic             busy;
    logic             wb;
    logic [DST_W-1:0] dst;
  } sb_entry_t;

endpackage

// File: rtl/definitions.sv
// Bus width macros shared by the OVI core-side blocks.
`ifndef OVI_DEFINITIONS_SV
`define OVI_DEFINITIONS_SV
`define OVI_INSTR_WIDTH      32
`define OVI_VL_WIDTH         14
`define OVI_SEW_WIDTH        3
`define OVI_DATA_WIDTH       32
`define OVI_SCALAROPND_WIDTH 64
`define OVI_SBID_WIDTH       5
`endif

// File: rtl/ovi_sb_table.sv
// Scoreboard entry array: one allocate port, one free/lookup port, and a
// registered scalar writeback produced when a busy entry with wb=1 is freed.
`ifndef OVI_DEFINITIONS_SV
`include "definitions.sv"
`endif

module ovi_sb_table
  import ovi_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                allocValid_i,
  input  sb_id_t              allocIdx_i,
  input  logic                allocWb_i,
  input  logic [DST_W-1:0]    allocDst_i,
  input  logic                freeValid_i,
  input  sb_id_t              freeIdx_i,
  input  logic [DATA_W-1:0]   freeData_i,
  output logic [SB_DEPTH-1:0] busy_o,
  output logic                freeHit_o,
  output logic                wbValid_o,
  output logic [DATA_W-1:0]   wbData_o,
  output logic [DST_W-1:0]    wbDst_o
);

  sb_entry_t [SB_DEPTH-1:0] entries_q, entries_d;
  logic                     wbValid_q;
  logic [DATA_W-1:0]        wbData_q;
  logic [DST_W-1:0]         wbDst_q;
  logic                     wbFire;

  assign freeHit_o = freeValid_i && entries_q[freeIdx_i].busy;
  assign wbFire    = freeHit_o && entries_q[freeIdx_i].wb;

  // Allocation only targets idle entries and frees only busy ones, so the two
  // ports can never touch the same entry in one cycle.
  always_comb begin
    entries_d = entries_q;
    if (allocValid_i) begin
      entries_d[allocIdx_i] = '{busy: 1'b1, wb: allocWb_i, dst: allocDst_i};
    end
    if (freeHit_o) begin
      entries_d[freeIdx_i].busy = 1'b0;
    end
  end

  always_comb begin
    busy_o = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      busy_o[i] = entries_q[i].busy;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entries_q <= '0;
      wbValid_q <= 1'b0;
      wbData_q  <= '0;
      wbDst_q   <= '0;
    end else begin
      entries_q <= entries_d;
      wbValid_q <= wbFire;
      if (wbFire) begin
        wbData_q <= freeData_i;
        wbDst_q  <= entries_q[freeIdx_i].dst;
      end
    end
  end

  assign wbValid_o = wbValid_q;
  assign wbData_o  = wbData_q;
  assign wbDst_o   = wbDst_q;

endmodule

// File: rtl/ovi_issue_ctrl.sv
// Core-side OVI issue controller: credit-gated issue, in-order dispatch one
// cycle later, and completion matching back to scalar writebacks.
`ifndef OVI_DEFINITIONS_SV
`include "definitions.sv"
`endif

module ovi_issue_ctrl
  import ovi_pkg::*;
#(
  parameter int ISSUE_CREDITS = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             core_issue_valid,
  input  logic [`OVI_INSTR_WIDTH-1:0]      core_issue_instr,
  input  logic [`OVI_VL_WIDTH-1:0]         core_issue_vl,
  input  logic [`OVI_SEW_WIDTH-1:0]        core_issue_sew,
  input  logic [`OVI_DATA_WIDTH-1:0]       core_issue_opnd,
  input  logic                             core_issue_wb,
  output logic                             core_issue_ready,
  output logic                             core_completed_valid,
  output logic [`OVI_DATA_WIDTH-1:0]       core_completed_data,
  output logic [4:0]                       core_completed_dst,
  output logic                             vpu_issue_valid,
  output logic [`OVI_INSTR_WIDTH-1:0]      vpu_issue_instr,
  output logic [`OVI_SCALAROPND_WIDTH-1:0] vpu_issue_scalar_opnd,
  output logic [`OVI_SBID_WIDTH-1:0]       vpu_issue_sb_id,
  output logic [`OVI_SEW_WIDTH-1:0]        vpu_issue_vsew,
  output logic [`OVI_VL_WIDTH-1:0]         vpu_issue_vl,
  input  logic                             vpu_issue_credit,
  output logic                             vpu_dispatch_valid,
  output logic [`OVI_SBID_WIDTH-1:0]       vpu_dispatch_sb_id,
  output logic                             vpu_dispatch_next_senior,
  output logic                             vpu_dispatch_kill,
  input  logic                             vpu_completed_valid,
  input  logic [`OVI_SBID_WIDTH-1:0]       vpu_completed_sb_id,
  input  logic [`OVI_SCALAROPND_WIDTH-1:0] vpu_completed_dest_reg,
  input  logic                             vpu_completed_illegal,
  output logic                             err_illegal,
  output logic                             err_protocol,
  output logic [5:0]                       outstanding
);

  localparam logic [CRED_W-1:0] CRED_MAX = 4'(ISSUE_CREDITS);

  logic [CRED_W-1:0]   cred_q, cred_d;
  sb_id_t              nextSb_q;
  logic [OUTST_W-1:0]  outstanding_q, outstanding_d;
  logic                errIllegal_q, errProtocol_q;
  logic                issueValid_q;
  logic [INSTR_W-1:0]  issueInstr_q;
  logic [SCALAR_W-1:0] issueOpnd_q;
  sb_id_t              issueSb_q;
  logic [SEW_W-1:0]    issueSew_q;
  logic [VL_W-1:0]     issueVl_q;
  logic                dispatchValid_q;
  sb_id_t              dispatchSb_q;

  logic [SB_DEPTH-1:0] busy;
  logic                accept;
  logic                sbHit;
  logic                credOverflow;
  logic                unusedDestHi;

  assign core_issue_ready = (cred_q != '0) && !busy[nextSb_q];
  assign accept           = core_issue_valid && core_issue_ready;
  assign unusedDestHi     = ^vpu_completed_dest_reg[SCALAR_W-1:DATA_W];

  ovi_sb_table u_sbTable (
    .clk          (clk),
    .rst          (rst),
    .allocValid_i (accept),
    .allocIdx_i   (nextSb_q),
    .allocWb_i    (core_issue_wb),
    .allocDst_i   (core_issue_instr[11:7]),
    .freeValid_i  (vpu_completed_valid),
    .freeIdx_i    (vpu_completed_sb_id),
    .freeData_i   (vpu_completed_dest_reg[DATA_W-1:0]),
    .busy_o       (busy),
    .freeHit_o    (sbHit),
    .wbValid_o    (core_completed_valid),
    .wbData_o     (core_completed_data),
    .wbDst_o      (core_completed_dst)
  );

  // A credit returned while the counter is already full has nowhere to go.
  always_comb begin
    cred_d       = cred_q;
    credOverflow = 1'b0;
    if (accept && !vpu_issue_credit) begin
      cred_d = cred_q - 4'd1;
    end else if (!accept && vpu_issue_credit) begin
      if (cred_q == CRED_MAX) begin
        credOverflow = 1'b1;
      end else begin
        cred_d = cred_q + 4'd1;
      end
    end
  end

  assign outstanding_d = outstanding_q + OUTST_W'(accept) - OUTST_W'(sbHit);

  always_ff @(posedge clk) begin
    if (rst) begin
      cred_q          <= CRED_MAX;
      nextSb_q        <= '0;
      outstanding_q   <= '0;
      errIllegal_q    <= 1'b0;
      errProtocol_q   <= 1'b0;
      issueValid_q    <= 1'b0;
      issueInstr_q    <= '0;
      issueOpnd_q     <= '0;
      issueSb_q       <= '0;
      issueSew_q      <= '0;
      issueVl_q       <= '0;
      dispatchValid_q <= 1'b0;
      dispatchSb_q    <= '0;
    end else begin
      cred_q          <= cred_d;
      outstanding_q   <= outstanding_d;
      errIllegal_q    <= errIllegal_q | (sbHit & vpu_completed_illegal);
      errProtocol_q   <= errProtocol_q | credOverflow | (vpu_completed_valid & ~sbHit);
      issueValid_q    <= accept;
      dispatchValid_q <= issueValid_q;
      dispatchSb_q    <= issueSb_q;
      if (accept) begin
        nextSb_q     <= nextSb_q + sb_id_t'(1);
        issueInstr_q <= core_issue_instr;
        issueOpnd_q  <= {{(SCALAR_W-DATA_W){1'b0}}, core_issue_opnd};
        issueSb_q    <= nextSb_q;
        issueSew_q   <= core_issue_sew;
        issueVl_q    <= core_issue_vl;
      end
    end
  end

  assign vpu_issue_valid          = issueValid_q;
  assign vpu_issue_instr          = issueInstr_q;
  assign vpu_issue_scalar_opnd    = issueOpnd_q;
  assign vpu_issue_sb_id          = issueSb_q;
  assign vpu_issue_vsew           = issueSew_q;
  assign vpu_issue_vl             = issueVl_q;
  assign vpu_dispatch_valid       = dispatchValid_q;
  assign vpu_dispatch_sb_id       = dispatchSb_q;
  assign vpu_dispatch_next_senior = dispatchValid_q;
  assign vpu_dispatch_kill        = 1'b0;
  assign err_illegal              = errIllegal_q;
  assign err_protocol             = errProtocol_q;
  assign outstanding              = outstanding_q;

endmodule
